data_mem_requester: RTL and testbench

//   Initiator side of the DataMemory interface. Accepts one load/store request at a time from the

---
 rtl/data_mem_requester.sv | 124 ++++++++++++
 tb/tb_data_mem_requester.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_requester.sv
// Initiator for the DataMemory port: takes one load/store at a time over a valid/ready
// request channel, performs a single-cycle access and returns the result over a response channel.
module data_mem_requester #(
  parameter int ADDR_WORDS = 1024,
  parameter int DATA_W     = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              mem_write,
  output logic [31:0]       mem_daddress,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam logic [31:0] ADDR_LIMIT = 32'(ADDR_WORDS);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              mem_write_q, mem_write_d;
  logic [31:0]       mem_daddress_q, mem_daddress_d;
  logic [DATA_W-1:0] mem_din_q, mem_din_d;
  logic              is_load_q, is_load_d;
  logic              resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
  logic              resp_err_q, resp_err_d;
  logic              addr_in_range;

  // Unsigned 32-bit compare: 0xFFFFFFFF must never alias into the array.
  assign addr_in_range = (req_addr < ADDR_LIMIT);

  always_comb begin
    state_d        = state_q;
    mem_write_d    = mem_write_q;
    mem_daddress_d = mem_daddress_q;
    mem_din_d      = mem_din_q;
    is_load_d      = is_load_q;
    resp_valid_d   = resp_valid_q;
    resp_rdata_d   = resp_rdata_q;
    resp_err_d     = resp_err_q;

    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          if (addr_in_range) begin
            mem_daddress_d = req_addr;
            mem_din_d      = req_wdata;
            mem_write_d    = req_write;
            is_load_d      = ~req_write;
            state_d        = ACCESS;
          end else begin
            resp_err_d   = 1'b1;
            resp_rdata_d = '0;
            resp_valid_d = 1'b1;
            state_d      = RESP;
          end
        end
      end
      ACCESS: begin
        // DataMemory has acted on the negedge inside this cycle, so dout is already valid.
        mem_write_d  = 1'b0;
        resp_rdata_d = is_load_q ? mem_dout : '0;
        resp_err_d   = 1'b0;
        resp_valid_d = 1'b1;
        state_d      = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          state_d      = IDLE;
        end
      end
      default: begin
        mem_write_d  = 1'b0;
        resp_valid_d = 1'b0;
        state_d      = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      mem_write_q    <= 1'b0;
      mem_daddress_q <= '0;
      mem_din_q      <= '0;
      is_load_q      <= 1'b0;
      resp_valid_q   <= 1'b0;
      resp_rdata_q   <= '0;
      resp_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      mem_write_q    <= mem_write_d;
      mem_daddress_q <= mem_daddress_d;
      mem_din_q      <= mem_din_d;
      is_load_q      <= is_load_d;
      resp_valid_q   <= resp_valid_d;
      resp_rdata_q   <= resp_rdata_d;
      resp_err_q     <= resp_err_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = resp_rdata_q;
  assign resp_err     = resp_err_q;
  assign mem_write    = mem_write_q;
  assign mem_daddress = mem_daddress_q;
  assign mem_din      = mem_din_q;

endmodule

// File: tb/tb_data_mem_requester.sv
// Scoreboard bench for data_mem_requester with a negedge-updating DataMemory model.
module tb_data_mem_requester;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        mem_write;
  logic [31:0] mem_daddress;
  logic [31:0] mem_din;
  logic [31:0] mem_dout = '0;

  data_mem_requester #(.ADDR_WORDS(1024), .DATA_W(32)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_write(mem_write), .mem_daddress(mem_daddress), .mem_din(mem_din),
    .mem_dout(mem_dout)
  );

  always #5 clock = ~clock;

  typedef struct packed { logic [31:0] rdata; logic err; } resp_t;
  resp_t exp_q[$];
  int    resp_cyc_q[$];

  logic [31:0] mem [0:1023];
  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int wr_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(posedge clock) cyc++;

  // DataMemory model: write and read both happen on the falling edge.
  always @(negedge clock) begin
    if (mem_write) mem[mem_daddress[9:0]] = mem_din;
    mem_dout <= mem[mem_daddress[9:0]];
  end

  // Monitor: a handshake completes at the next posedge whenever valid & ready here.
  always @(negedge clock) begin
    if (!reset) begin
      if (mem_write) wr_cnt++;
      if (resp_valid && resp_ready) begin
        resp_cyc_q.push_back(cyc);
        if (exp_q.size() == 0) begin
          chk("unexpected_resp", 32'd1, 32'd0);
        end else begin
          resp_t e;
          e = exp_q.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'd0, resp_err}, {31'd0, e.err});
        end
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 20) begin
      step();
      n++;
    end
    if (!req_ready) chk("req_ready_timeout", 32'd0, 32'd1);
  endtask

  // Returns #1 after the accepting edge with req_valid already dropped.
  task automatic do_req(input logic w, input logic [31:0] a, input logic [31:0] d,
                        input logic push, input logic [31:0] er, input logic ee);
    resp_t e;
    wait_ready();
    if (push) begin
      e.rdata = er;
      e.err   = ee;
      exp_q.push_back(e);
    end
    req_valid = 1'b1;
    req_write = w;
    req_addr  = a;
    req_wdata = d;
    step();
    req_valid = 1'b0;
  endtask

  initial begin
    int w0;
    int c0;
    int c1;
    for (int i = 0; i < 1024; i++) mem[i] = 32'd0;
    mem[2] = 32'h22;
    mem[3] = 32'h33;
    mem[7] = 32'h7;
    mem[9] = 32'h99;

    step();
    step();
    reset = 1'b0;
    #1;
    chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_mem_write", {31'd0, mem_write}, 32'd0);
    chk("rst_daddress", mem_daddress, 32'd0);
    chk("rst_din", mem_din, 32'd0);
    chk("rst_rdata", resp_rdata, 32'd0);
    chk("rst_req_ready", {31'd0, req_ready}, 32'd1);

    // 1: store then load
    w0 = wr_cnt;
    do_req(1'b1, 32'd5, 32'hDEADBEEF, 1'b1, 32'd0, 1'b0);
    chk("t1_access_write", {31'd0, mem_write}, 32'd1);
    chk("t1_daddress", mem_daddress, 32'd5);
    chk("t1_din", mem_din, 32'hDEADBEEF);
    wait_ready();
    chk("t1_write_pulses", 32'(wr_cnt - w0), 32'd1);
    chk("t1_mem5", mem[5], 32'hDEADBEEF);
    do_req(1'b0, 32'd5, 32'd0, 1'b1, 32'hDEADBEEF, 1'b0);
    wait_ready();

    // 2: out-of-range load
    w0 = wr_cnt;
    do_req(1'b0, 32'd1024, 32'd0, 1'b1, 32'd0, 1'b1);
    chk("t2_valid_n1", {31'd0, resp_valid}, 32'd1);
    chk("t2_err_n1", {31'd0, resp_err}, 32'd1);
    chk("t2_rdata_n1", resp_rdata, 32'd0);
    chk("t2_daddr_kept", mem_daddress, 32'd5);
    wait_ready();
    chk("t2_no_write", 32'(wr_cnt - w0), 32'd0);
    do_req(1'b0, 32'hFFFFFFFF, 32'd0, 1'b1, 32'd0, 1'b1);
    wait_ready();

    // 3: back-pressured response
    resp_ready = 1'b0;
    do_req(1'b0, 32'd7, 32'd0, 1'b1, 32'h7, 1'b0);
    step();
    for (int k = 0; k < 3; k++) begin
      chk("t3_hold_valid", {31'd0, resp_valid}, 32'd1);
      chk("t3_hold_rdata", resp_rdata, 32'h7);
      chk("t3_req_ready_low", {31'd0, req_ready}, 32'd0);
      step();
    end
    resp_ready = 1'b1;
    wait_ready();

    // 4: back-to-back loads, req_valid held high
    resp_cyc_q.delete();
    exp_q.push_back('{rdata: 32'h22, err: 1'b0});
    exp_q.push_back('{rdata: 32'h33, err: 1'b0});
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 32'd2;
    step();
    req_addr = 32'd3;
    step();
    wait_ready();
    step();
    req_valid = 1'b0;
    wait_ready();
    step();
    if (resp_cyc_q.size() == 2) begin
      c0 = resp_cyc_q.pop_front();
      c1 = resp_cyc_q.pop_front();
      chk("t4_spacing", 32'(c1 - c0), 32'd3);
    end else begin
      chk("t4_resp_count", 32'(resp_cyc_q.size()), 32'd2);
    end

    // 5: reset during ACCESS before the negedge
    do_req(1'b1, 32'd9, 32'h1234, 1'b0, 32'd0, 1'b0);
    reset = 1'b1;
    #1;
    chk("t5_write_drop", {31'd0, mem_write}, 32'd0);
    chk("t5_valid", {31'd0, resp_valid}, 32'd0);
    chk("t5_daddr", mem_daddress, 32'd0);
    chk("t5_din", mem_din, 32'd0);
    step();
    reset = 1'b0;
    step();
    step();
    chk("t5_mem9", mem[9], 32'h99);
    chk("t5_no_resp", {31'd0, resp_valid}, 32'd0);

    // 6: req_* changes after acceptance are ignored
    do_req(1'b1, 32'd11, 32'hAAAA, 1'b1, 32'd0, 1'b0);
    req_addr  = 32'd12;
    req_wdata = 32'hBBBB;
    req_write = 1'b0;
    wait_ready();
    chk("t6_mem11", mem[11], 32'hAAAA);
    chk("t6_mem12", mem[12], 32'd0);
    do_req(1'b0, 32'd11, 32'd0, 1'b1, 32'hAAAA, 1'b0);
    wait_ready();
    step();

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
